reflet_float_add_pipe: RTL and testbench
========================================

Name: reflet_float_add_pipe

Overview:
- Pipelined IEEE-754-style floating-point adder/subtractor, parametrised in float width.
- Four pipeline stages; accepts one operation per cycle under a valid/ready handshake.
- Rounds to nearest, ties to even, and reports exception flags.
- Sits between the register file/issue logic and the FPU result bus, replacing the single-cycle combinational adder in timing-critical builds.

Parameters:
- float_size, 32, total float width: 16, 32 or 64. Exponent and mantissa split come from mantissa_size()/exponent_size() in reflet_float.vh.
- flush_denormals, 1, when 1 any operand or result with exponent 0 is treated as signed zero. Only value 1 is required in this generation.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in1  input  float_size  operand A
- in2  input  float_size  operand B
- op_sub  input  1  1: in1 - in2; 0: in1 + in2
- in_valid  input  1  operands and op_sub valid this cycle
- in_ready  output  1  pipeline can accept an operation this cycle
- sum  output  float_size  result
- flags  output  4  {invalid, overflow, underflow, inexact}
- out_valid  output  1  sum/flags valid
- out_ready  input  1  consumer accepts sum this cycle

Behaviour:
- Reset (reset low, asynchronous) clears all stage valid bits. out_valid=0, sum=0, flags=0. in_ready=1 from the first cycle after reset deasserts. In-flight operations are discarded, with no partial output.
- Handshake: transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready. sum/flags stay stable while out_valid&&!out_ready.
- Stall is global: advance = !out_valid || out_ready, and in_ready = advance. Every stage register enables on advance. Bubbles propagate as invalid stages.
- Latency is exactly 4 cycles from accept to out_valid when out_ready stays high. Throughput is 1/cycle.
- S1 unpack/swap:
  - Negate in2 sign when op_sub=1.
  - Classify each operand as zero (exp=0), inf (exp all-ones, mnt=0) or NaN (exp all-ones, mnt!=0).
  - Order the operands by |value|: compare exponents, then mantissas. Larger magnitude = max.
  - Register exponent difference d = exp_max-exp_min.
- S2 align:
  - Significands widen to {hidden 1, mnt, guard, round, sticky}.
  - min is shifted right by d. If d > mantissa_size+2, min becomes sticky only.
  - Sticky = OR of all bits shifted out.
- S3 add: add when signs are equal, else subtract min from max. One carry bit is kept; the result is never negative.
- S4 normalise/round/pack:
  - On carry, shift right 1 and exp+1. Otherwise shift left by leading-zero count and exp-lzc.
  - RNE: increment when G && (R||S||LSB). Renormalise if rounding carries out.
  - Sign of result = sign of max.
- Special cases, evaluated in S1 and carried as a forced result:
  - Any NaN, or inf + (-inf): quiet NaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - One inf: that inf, no flags.
  - Both operands zero: +0, except (-0)+(-0) = -0.
  - Exact cancellation: +0, no flags.
- Overflow: final exp >= all-ones gives signed infinity, overflow=1, inexact=1.
- Underflow: final exp <= 0 gives signed zero, underflow=1, inexact=1 (flush).
- inexact=1 whenever any of G/R/S was nonzero before rounding.

Decomposition:
- Add to reflet_float.vh:
  - exp_bias(float_size)
  - qnan_value, inf_exp, ext_mnt_size = mantissa_size+3
  - flag bit index constants
- Sub-module reflet_float_lzc (parameter width): combinational leading-zero counter used in S4. It returns width when the input is all zero.

Test Plan:
- 0x3F800000 + 0x40000000, out_ready=1 → 0x40400000, flags=0, out_valid exactly 4 cycles after accept.
- 0x3F800000 - 0x3F800000 (op_sub=1) → 0x00000000, flags=0. Also 0x80000000 + 0x80000000 → 0x80000000.
- Rounding, flags=inexact:
  - 0x3F800000 + 0x33800000 (tie, even) → 0x3F800000.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow+inexact. 0x7F800000 + 0xFF800000 → 0x7FC00000 with invalid.
- 6 back-to-back ops with out_ready low for cycles 3-5:
  - No result lost or duplicated; order preserved.
  - in_ready low exactly while the output is stalled.
  - sum held stable during the stall.
- reset pulsed low mid-stream with 3 ops in flight → out_valid=0 asynchronously, no stale result emitted afterwards, next op returns correctly after 4 cycles.

Source files
------------

// File: rtl/reflet_float_add_pipe_pkg.sv
// Shared float-format helpers for the pipelined adder: field widths, special
// encodings and flag bit positions.
package reflet_float_add_pipe_pkg;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int mantissa_size(input int fs);
        case (fs)
            16:      return 10;
            64:      return 52;
            default: return 23;
        endcase
    endfunction

    function automatic int exponent_size(input int fs);
        case (fs)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int exp_bias(input int fs);
        return (1 << (exponent_size(fs) - 1)) - 1;
    endfunction

    function automatic int inf_exp(input int fs);
        return (1 << exponent_size(fs)) - 1;
    endfunction

    // mantissa plus guard, round and sticky
    function automatic int ext_mnt_size(input int fs);
        return mantissa_size(fs) + 3;
    endfunction

    function automatic logic [63:0] qnan_value(input int fs);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exponent_size(fs); i++) v[mantissa_size(fs) + i] = 1'b1;
        v[mantissa_size(fs) - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reflet_float_lzc.sv
// Combinational leading-zero counter; reports width for an all-zero input.
module reflet_float_lzc #(
    parameter int width = 27
) (
    input  logic [width-1:0]             data,
    output logic [$clog2(width+1)-1:0]   count
);
    localparam int CW = $clog2(width + 1);

    // ascending scan: the highest set bit is the last to write
    always_comb begin
        count = CW'(width);
        for (int i = 0; i < width; i++)
            if (data[i]) count = CW'(width - 1 - i);
    end
endmodule

// File: rtl/reflet_float_add_pipe.sv
// Four-stage floating-point add/subtract: unpack/swap, align, add,
// normalise/round/pack. One global stall enable covers every stage.
module reflet_float_add_pipe
    import reflet_float_add_pipe_pkg::*;
#(
    parameter int float_size      = 32,
    parameter bit flush_denormals = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    input  logic                  op_sub,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [float_size-1:0] sum,
    output logic [3:0]            flags,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int M      = mantissa_size(float_size);
    localparam int E      = exponent_size(float_size);
    localparam int SW     = ext_mnt_size(float_size) + 1;
    localparam int LW     = $clog2(SW + 1);
    localparam int XW     = E + 2;
    localparam int STAGES = 4;
    localparam int INF_EXP = inf_exp(float_size);
    localparam logic [63:0] QNAN64 = qnan_value(float_size);

    typedef struct packed {
        logic                  en;
        logic [float_size-1:0] val;
        logic [3:0]            flg;
    } special_t;

    logic            advance;
    logic [STAGES:1] vld_pipe;

    assign advance   = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge reset)
        if (!reset)       vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};

    // ---- S1: unpack, classify, order by magnitude
    logic         sa, sb;
    logic [E-1:0] ea, eb, e_max, e_min;
    logic [M-1:0] ma, mb, m_max, m_min;
    logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    special_t     sp_d;

    assign sa = in1[float_size-1];
    assign ea = in1[float_size-2:M];
    assign ma = in1[M-1:0];
    assign sb = in2[float_size-1] ^ op_sub;
    assign eb = in2[float_size-2:M];
    assign mb = in2[M-1:0];

    assign a_zero = (ea == '0) && (flush_denormals || ma == '0);
    assign b_zero = (eb == '0) && (flush_denormals || mb == '0);
    assign a_inf  = (&ea) && (ma == '0);
    assign b_inf  = (&eb) && (mb == '0);
    assign a_nan  = (&ea) && (ma != '0);
    assign b_nan  = (&eb) && (mb != '0);
    assign a_big  = {ea, ma} >= {eb, mb};

    assign e_max = a_big ? ea : eb;
    assign e_min = a_big ? eb : ea;
    assign m_max = a_big ? ma : mb;
    assign m_min = a_big ? mb : ma;

    always_comb begin
        sp_d = '0;
        if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) begin
            sp_d.en  = 1'b1;
            sp_d.val = QNAN64[float_size-1:0];
            sp_d.flg[FLAG_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            sp_d.en  = 1'b1;
            sp_d.val = {a_inf ? sa : sb, {E{1'b1}}, {M{1'b0}}};
        end else if (a_zero && b_zero) begin
            sp_d.en  = 1'b1;
            sp_d.val = {sa & sb, {(float_size-1){1'b0}}};
        end
    end

    logic         s1_sign, s1_sub, s1_hmin;
    logic [E-1:0] s1_emax, s1_d;
    logic [M-1:0] s1_mmax, s1_mmin;
    special_t     s1_sp;

    // a flushed min operand contributes a zero significand
    always_ff @(posedge clk)
        if (advance) begin
            s1_sign <= a_big ? sa : sb;
            s1_sub  <= sa ^ sb;
            s1_emax <= e_max;
            s1_d    <= e_max - e_min;
            s1_mmax <= m_max;
            s1_hmin <= e_min != '0;
            s1_mmin <= (e_min != '0) ? m_min : '0;
            s1_sp   <= sp_d;
        end

    // ---- S2: align min significand with sticky collection
    logic [SW-1:0]   big_sig, small_sig, small_al;
    logic [2*SW-1:0] small_wide;

    assign big_sig    = {1'b1, s1_mmax, 3'b000};
    assign small_sig  = {s1_hmin, s1_mmin, 3'b000};
    assign small_wide = {small_sig, {SW{1'b0}}} >> s1_d;

    always_comb begin
        if (int'(s1_d) > M + 2)
            small_al = {{(SW-1){1'b0}}, |small_sig};
        else
            small_al = {small_wide[2*SW-1:SW+1], small_wide[SW] | (|small_wide[SW-1:0])};
    end

    logic          s2_sign, s2_sub;
    logic [E-1:0]  s2_emax;
    logic [SW-1:0] s2_big, s2_small;
    special_t      s2_sp;

    always_ff @(posedge clk)
        if (advance) begin
            s2_sign  <= s1_sign;
            s2_sub   <= s1_sub;
            s2_emax  <= s1_emax;
            s2_big   <= big_sig;
            s2_small <= small_al;
            s2_sp    <= s1_sp;
        end

    // ---- S3: magnitude add/subtract; max >= min so never negative
    logic          s3_sign;
    logic [E-1:0]  s3_emax;
    logic [SW:0]   s3_sum;
    special_t      s3_sp;

    always_ff @(posedge clk)
        if (advance) begin
            s3_sign <= s2_sign;
            s3_emax <= s2_emax;
            s3_sum  <= s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                              : ({1'b0, s2_big} + {1'b0, s2_small});
            s3_sp   <= s2_sp;
        end

    // ---- S4: normalise, round to nearest even, pack
    logic [LW-1:0]        lz;
    logic [SW-1:0]        norm;
    logic signed [XW-1:0] exp_n, exp_f;
    logic [M+1:0]         rnd;
    logic [M-1:0]         mnt_f;
    logic                 grd, rbit, stk, inc;
    logic [float_size-1:0] res;
    logic [3:0]            res_flg;

    reflet_float_lzc #(.width(SW)) u_lzc (
        .data  (s3_sum[SW-1:0]),
        .count (lz)
    );

    always_comb begin
        if (s3_sum[SW]) begin
            norm  = {s3_sum[SW:2], s3_sum[1] | s3_sum[0]};
            exp_n = XW'(s3_emax) + XW'(1);
        end else begin
            norm  = s3_sum[SW-1:0] << lz;
            exp_n = XW'(s3_emax) - XW'(lz);
        end
    end

    assign grd   = norm[2];
    assign rbit  = norm[1];
    assign stk   = norm[0];
    assign inc   = grd && (rbit || stk || norm[3]);
    assign rnd   = {1'b0, norm[SW-1:3]} + (M+2)'(inc);
    assign exp_f = exp_n + XW'(rnd[M+1]);
    assign mnt_f = rnd[M+1] ? rnd[M:1] : rnd[M-1:0];

    always_comb begin
        res     = '0;
        res_flg = '0;
        if (s3_sp.en) begin
            res     = s3_sp.val;
            res_flg = s3_sp.flg;
        end else if (s3_sum == '0) begin
            res = '0;
        end else if (int'(exp_f) >= INF_EXP) begin
            res = {s3_sign, {E{1'b1}}, {M{1'b0}}};
            res_flg[FLAG_OVERFLOW] = 1'b1;
            res_flg[FLAG_INEXACT]  = 1'b1;
        end else if (int'(exp_f) <= 0) begin
            res = {s3_sign, {(float_size-1){1'b0}}};
            res_flg[FLAG_UNDERFLOW] = 1'b1;
            res_flg[FLAG_INEXACT]   = 1'b1;
        end else begin
            res = {s3_sign, exp_f[E-1:0], mnt_f};
            res_flg[FLAG_INEXACT] = grd | rbit | stk;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sum   <= '0;
            flags <= '0;
        end else if (advance) begin
            sum   <= res;
            flags <= res_flg;
        end

endmodule

// File: tb/tb_reflet_float_add_pipe.sv
// Directed bench with a scoreboard queue; a negedge monitor pushes expected
// results on accept and pops/compares on every output handshake.
module tb_reflet_float_add_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in1, in2, sum;
    logic        op_sub, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  flags;

    typedef struct {
        logic [31:0] s;
        logic [3:0]  f;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_new;
    logic [31:0] exp_sum, held_sum;
    logic [3:0]  exp_flags, held_flags;
    bit          lat_mark, held;
    int          cyc = 0;
    int          checks = 0, errors = 0, n_out = 0, n_out0;

    reflet_float_add_pipe #(.float_size(32), .flush_denormals(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in1       (in1),
        .in2       (in2),
        .op_sub    (op_sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        held <= 1'b0;
        if (reset) begin
            if (held) begin
                chk("hold_sum", sum, held_sum);
                chk("hold_flags", flags, held_flags);
            end
            if (in_valid && in_ready) begin
                e_new.s   = exp_sum;
                e_new.f   = exp_flags;
                e_new.acc = cyc;
                e_new.lat = lat_mark;
                sb.push_back(e_new);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    chk("sum", sum, sb[0].s);
                    chk("flags", flags, sb[0].f);
                    if (out_ready) begin
                        if (sb[0].lat) chk("latency", cyc - sb[0].acc, 4);
                        void'(sb.pop_front());
                        n_out++;
                    end else begin
                        held       <= 1'b1;
                        held_sum   <= sum;
                        held_flags <= flags;
                    end
                end
            end
            chk("in_ready", in_ready, !(out_valid && !out_ready));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] es, input logic [3:0] ef);
        bit acc;
        int k;
        in1 = a; in2 = b; op_sub = sub;
        exp_sum = es; exp_flags = ef;
        in_valid = 1'b1;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = in_ready;
            k++;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; op_sub = 1'b0;
        out_ready = 1'b1; lat_mark = 1'b0; exp_sum = '0; exp_flags = '0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", flags, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", in_ready, 1'b1);

        // isolated op for exact latency
        lat_mark = 1'b1;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        lat_mark = 1'b0;
        drain();

        // directed vectors, streamed back to back
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        send(32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000);
        send(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000);
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
        drain();

        // six back-to-back ops with the consumer stalled for cycles 3..5
        n_out0 = n_out;
        fork
            begin
                send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
                send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
                send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
                send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
                send(32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000);
                send(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", n_out - n_out0, 6);

        // reset with three ops in flight and one presented at the output
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        @(posedge clk); #3;
        chk("pre_reset_valid", out_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_flags", flags, 0);
        sb.delete();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #2 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        lat_mark = 1'b1;
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        lat_mark = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
